// File: rtl/video_timing_pkg.sv
// ============================================================================
// video_timing_pkg : shared raster timing constants, helpers, types | rev 1.0
// ============================================================================
`default_nettype none

package video_timing_pkg;

  localparam int DEF_ACTIVE_H = 1280;
  localparam int DEF_FP_H     = 110;
  localparam int DEF_SYNC_H   = 40;
  localparam int DEF_BP_H     = 220;
  localparam int DEF_ACTIVE_V = 720;
  localparam int DEF_FP_V     = 5;
  localparam int DEF_SYNC_V   = 5;
  localparam int DEF_BP_V     = 20;
  localparam int DEF_FPS      = 60;

  function automatic int total_h(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int total_v(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Never narrower than one bit, so a modulus of 1 still yields a legal vector.
  function automatic int cnt_width(input int modulus);
    return (modulus <= 2) ? 1 : $clog2(modulus);
  endfunction

  localparam int DEF_TOTAL_H = total_h(DEF_ACTIVE_H, DEF_FP_H, DEF_SYNC_H, DEF_BP_H);
  localparam int DEF_TOTAL_V = total_v(DEF_ACTIVE_V, DEF_FP_V, DEF_SYNC_V, DEF_BP_V);
  localparam int DEF_H_W     = cnt_width(DEF_TOTAL_H);
  localparam int DEF_V_W     = cnt_width(DEF_TOTAL_V);
  localparam int DEF_FC_W    = cnt_width(DEF_FPS);

  typedef struct packed {
    logic hs;
    logic vs;
    logic ad;
    logic nf;
  } sync_flags_t;

endpackage

`default_nettype wire

// File: rtl/wrap_counter.sv
// ============================================================================
// wrap_counter : enabled modulo counter with wrap pulse and look-ahead | rev 1.0
// ============================================================================
`default_nettype none

module wrap_counter
  import video_timing_pkg::*;
#(
  parameter  int MODULUS   = 2,
  parameter  int RESET_VAL = 0,
  localparam int W         = cnt_width(MODULUS)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);
  localparam logic [W-1:0] INIT = W'(RESET_VAL);

  assign wrap = en && (count == LAST);

  always_comb begin
    count_next = count;
    if (en) begin
      count_next = (count == LAST) ? '0 : count + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= INIT;
    end else begin
      count <= count_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/video_sig_gen.sv
// ============================================================================
// video_sig_gen : registered raster timing generator (counters, syncs, frame) | rev 1.0
// ============================================================================
`default_nettype none

module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter  int ACTIVE_H = DEF_ACTIVE_H,
  parameter  int FP_H     = DEF_FP_H,
  parameter  int SYNC_H   = DEF_SYNC_H,
  parameter  int BP_H     = DEF_BP_H,
  parameter  int ACTIVE_V = DEF_ACTIVE_V,
  parameter  int FP_V     = DEF_FP_V,
  parameter  int SYNC_V   = DEF_SYNC_V,
  parameter  int BP_V     = DEF_BP_V,
  parameter  int FPS      = DEF_FPS,
  localparam int TOTAL_H  = total_h(ACTIVE_H, FP_H, SYNC_H, BP_H),
  localparam int TOTAL_V  = total_v(ACTIVE_V, FP_V, SYNC_V, BP_V),
  localparam int H_W      = cnt_width(TOTAL_H),
  localparam int V_W      = cnt_width(TOTAL_V),
  localparam int FC_W     = cnt_width(FPS)
) (
  input  logic            clk_in,
  input  logic            rst_in,
  output logic [H_W-1:0]  hcount_out,
  output logic [V_W-1:0]  vcount_out,
  output logic            hs_out,
  output logic            vs_out,
  output logic            ad_out,
  output logic            nf_out,
  output logic [FC_W-1:0] fc_out
);

  localparam logic [H_W-1:0] ACT_H    = H_W'(ACTIVE_H);
  localparam logic [H_W-1:0] HS_START = H_W'(ACTIVE_H + FP_H);
  localparam logic [H_W-1:0] HS_END   = H_W'(ACTIVE_H + FP_H + SYNC_H);
  localparam logic [V_W-1:0] ACT_V    = V_W'(ACTIVE_V);
  localparam logic [V_W-1:0] VS_START = V_W'(ACTIVE_V + FP_V);
  localparam logic [V_W-1:0] VS_END   = V_W'(ACTIVE_V + FP_V + SYNC_V);

  logic [H_W-1:0]  h_next;
  logic [V_W-1:0]  v_next;
  logic            h_wrap;
  logic            v_wrap_unused;
  logic [FC_W-1:0] fc_next_unused;
  logic            fc_wrap_unused;
  sync_flags_t     flags_next;
  sync_flags_t     flags_q;

  // Parked at the last position so the first edge after reset lands on (0,0).
  wrap_counter #(.MODULUS(TOTAL_H), .RESET_VAL(TOTAL_H - 1)) u_hcnt (
    .clk        (clk_in),
    .rst_n      (rst_in),
    .en         (1'b1),
    .count      (hcount_out),
    .count_next (h_next),
    .wrap       (h_wrap)
  );

  wrap_counter #(.MODULUS(TOTAL_V), .RESET_VAL(TOTAL_V - 1)) u_vcnt (
    .clk        (clk_in),
    .rst_n      (rst_in),
    .en         (h_wrap),
    .count      (vcount_out),
    .count_next (v_next),
    .wrap       (v_wrap_unused)
  );

  wrap_counter #(.MODULUS(FPS), .RESET_VAL(0)) u_fcnt (
    .clk        (clk_in),
    .rst_n      (rst_in),
    .en         (nf_out),
    .count      (fc_out),
    .count_next (fc_next_unused),
    .wrap       (fc_wrap_unused)
  );

  // Decode the position the counters move to, so flags and counters share a register stage.
  always_comb begin
    flags_next    = '0;
    flags_next.ad = (h_next < ACT_H) && (v_next < ACT_V);
    flags_next.hs = (h_next >= HS_START) && (h_next < HS_END);
    flags_next.vs = (v_next >= VS_START) && (v_next < VS_END);
    flags_next.nf = (h_next == ACT_H) && (v_next == ACT_V);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_next;
    end
  end

  assign hs_out = flags_q.hs;
  assign vs_out = flags_q.vs;
  assign ad_out = flags_q.ad;
  assign nf_out = flags_q.nf;

endmodule

`default_nettype wire

// File: tb/tb_video_sig_gen.sv
// ============================================================================
// tb_video_sig_gen : scoreboard bench, small and default raster with random resets | rev 1.0
// ============================================================================
`default_nettype none

module tb_video_sig_gen;

  typedef struct {
    int h;
    int v;
    int hs;
    int vs;
    int ad;
    int nf;
    int fc;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;

  logic [2:0]  hc_s;
  logic [2:0]  vc_s;
  logic        hs_s, vs_s, ad_s, nf_s;
  logic [1:0]  fc_s;

  logic [10:0] hc_d;
  logic [9:0]  vc_d;
  logic        hs_d, vs_d, ad_d, nf_d;
  logic [5:0]  fc_d;

  exp_t q_s[$];
  exp_t q_d[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   t        = 0;

  always #5 clk_in = ~clk_in;

  video_sig_gen #(
    .ACTIVE_H(4), .FP_H(1), .SYNC_H(2), .BP_H(1),
    .ACTIVE_V(3), .FP_V(1), .SYNC_V(1), .BP_V(1),
    .FPS(3)
  ) dut_s (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .hcount_out (hc_s),
    .vcount_out (vc_s),
    .hs_out     (hs_s),
    .vs_out     (vs_s),
    .ad_out     (ad_s),
    .nf_out     (nf_s),
    .fc_out     (fc_s)
  );

  video_sig_gen dut_d (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .hcount_out (hc_d),
    .vcount_out (vc_d),
    .hs_out     (hs_d),
    .vs_out     (vs_d),
    .ad_out     (ad_d),
    .nf_out     (nf_d),
    .fc_out     (fc_d)
  );

  // Reference: position is elapsed cycles since release modulo the frame length.
  function automatic exp_t model(input int tt, input bit park,
                                 input int ah, input int fh, input int sh, input int bh,
                                 input int av, input int fv, input int sv, input int bv,
                                 input int fps);
    exp_t e;
    int th, tv, fr, p, nfi;
    th = ah + fh + sh + bh;
    tv = av + fv + sv + bv;
    fr = th * tv;
    if (park) begin
      e.h = th - 1; e.v = tv - 1;
      e.hs = 0; e.vs = 0; e.ad = 0; e.nf = 0; e.fc = 0;
    end else begin
      p    = tt % fr;
      e.h  = p % th;
      e.v  = p / th;
      e.ad = (e.h < ah && e.v < av) ? 1 : 0;
      e.hs = (e.h >= ah + fh && e.h < ah + fh + sh) ? 1 : 0;
      e.vs = (e.v >= av + fv && e.v < av + fv + sv) ? 1 : 0;
      e.nf = (e.h == ah && e.v == av) ? 1 : 0;
      nfi  = av * th + ah;
      e.fc = ((tt + fr - nfi - 1) / fr) % fps;
    end
    return e;
  endfunction

  task automatic push(input bit park);
    q_s.push_back(model(t, park, 4, 1, 2, 1, 3, 1, 1, 1, 3));
    q_d.push_back(model(t, park, 1280, 110, 40, 220, 720, 5, 5, 20, 60));
  endtask

  task automatic compare(input string nm, input exp_t e, input exp_t a);
    n_checks++;
    if (a != e) begin
      n_errors++;
      $display("FAIL %s @%0t: got h=%0d v=%0d hs=%0d vs=%0d ad=%0d nf=%0d fc=%0d, expected h=%0d v=%0d hs=%0d vs=%0d ad=%0d nf=%0d fc=%0d",
               nm, $time, a.h, a.v, a.hs, a.vs, a.ad, a.nf, a.fc,
               e.h, e.v, e.hs, e.vs, e.ad, e.nf, e.fc);
    end
  endtask

  always @(negedge clk_in) begin
    exp_t a;
    if (q_s.size() == 0 || q_d.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty @%0t: got sizes %0d/%0d, expected nonzero", $time, q_s.size(), q_d.size());
    end else begin
      a = '{int'(hc_s), int'(vc_s), int'(hs_s), int'(vs_s), int'(ad_s), int'(nf_s), int'(fc_s)};
      compare("small", q_s.pop_front(), a);
      a = '{int'(hc_d), int'(vc_d), int'(hs_d), int'(vs_d), int'(ad_d), int'(nf_d), int'(fc_d)};
      compare("dflt", q_d.pop_front(), a);
    end
  end

  // Hold reset for n cycles; release lands between edges so the next edge shows (0,0).
  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      push(1'b1);
      if (i == n - 1) rst_in = 1'b1;
    end
    t = 0;
  endtask

  // Run n cycles then assert reset between edges; the next sample must already be parked.
  task automatic run_then_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      push(1'b0);
      t++;
    end
    @(posedge clk_in);
    #($urandom_range(1, 3));
    rst_in = 1'b0;
    push(1'b1);
  endtask

  initial begin
    hold_reset(5);
    run_then_reset(6000);
    for (int s = 0; s < 10; s++) begin
      hold_reset($urandom_range(1, 4));
      run_then_reset($urandom_range(20, 2500));
    end
    hold_reset(2);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_in);
      #1;
      push(1'b0);
      t++;
    end
    @(negedge clk_in);
    #1;
    n_checks++;
    if (q_s.size() != 0 || q_d.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got sizes %0d/%0d, expected 0/0", q_s.size(), q_d.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
